// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single-outstanding shared memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed DATA priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wea,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_wea,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wea_q, wea_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic   complete;
    logic   arb_en;
    logic   grant;
    owner_t winner;

    // Completion may land in RESP, or in REQ when the memory accepts and answers in one cycle.
    always_comb begin
        complete = !rst && m_rvalid &&
                   ((state_q == RESP) || ((state_q == REQ) && m_ready));
        arb_en   = !rst && ((state_q == IDLE) || complete);
        grant    = arb_en && (i_req || d_req);
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = (last_owner_q == FETCH) ? DATA : FETCH;
`else
            winner = DATA;
`endif
        end else if (d_req) begin
            winner = DATA;
        end else begin
            winner = FETCH;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wea_d        = wea_q;
        wdata_d      = wdata_q;
        if (grant) begin
            state_d      = REQ;
            owner_d      = winner;
            last_owner_d = winner;
            if (winner == DATA) begin
                addr_d  = d_addr;
                wea_d   = d_wea;
                wdata_d = d_wdata;
            end else begin
                addr_d  = i_addr;
                wea_d   = 4'b0000;
                wdata_d = '0;
            end
        end else if (complete) begin
            state_d = IDLE;
        end else if ((state_q == REQ) && m_ready) begin
            state_d = RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= FETCH;
            last_owner_q <= FETCH;
            addr_q       <= '0;
            wea_q        <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wea_q        <= wea_d;
            wdata_q      <= wdata_d;
        end
    end

    // Every output is forced low while reset is held, independent of register contents.
    always_comb begin
        i_ack    = grant && (winner == FETCH);
        d_ack    = grant && (winner == DATA);
        i_rvalid = complete && (owner_q == FETCH);
        d_rvalid = complete && (owner_q == DATA);
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
        m_req    = !rst && (state_q == REQ);
        m_addr   = rst ? '0 : addr_q;
        m_wea    = rst ? '0 : wea_q;
        m_wdata  = rst ? '0 : wdata_q;
        stall    = !rst && (((state_q != IDLE) && !complete) ||
                            (i_req && !i_ack) || (d_req && !d_ack));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_wea = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_wea;
    logic [31:0] m_wdata;
    logic        m_ready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        stall;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wea(d_wea), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wea(m_wea), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall(stall)
    );

    typedef struct packed {
        logic        is_data;
        logic [31:0] addr;
        logic [3:0]  wea;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        sb[$];
    logic        grant_log[$];
    int          ack_cycq[$];
    int          checks = 0;
    int          errors = 0;
    int          i_todo = 0, d_todo = 0;
    logic [31:0] i_addr_n = '0, d_addr_n = '0, d_wdata_n = '0;
    logic [3:0]  d_wea_n = '0;
    logic        rst_cmd = 1'b1;
    int          ready_dly = 0, resp_dly = 0, mm_wait = 0, mm_cnt = 0;
    logic [31:0] mm_addr = '0;
    logic        inflight = 1'b0, accepted = 1'b0, tb_last = 1'b0;
    int          reqcyc = 0, cyc = 0, comp_cyc = 0, mreq_cnt = 0;
    int          i_ack_cnt = 0, i_rv_cnt = 0, d_ack_cnt = 0, d_rv_cnt = 0;
    logic [31:0] last_i_rdata = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2402_000A;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic clear_counts();
        i_ack_cnt = 0; i_rv_cnt = 0; d_ack_cnt = 0; d_rv_cnt = 0; mreq_cnt = 0;
        grant_log.delete();
        ack_cycq.delete();
    endtask

    task automatic observe();
        logic exp_comp, elig, win, exp_i_ack, exp_d_ack, exp_stall, exp_mreq;
        txn_t cur, t;
        if (rst) begin
            checks++;
            if ({m_req, i_ack, d_ack, i_rvalid, d_rvalid, stall} !== 6'b0 || m_addr !== '0 ||
                m_wea !== '0 || m_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got m_req=%0b acks=%0b%0b rvalids=%0b%0b stall=%0b m_addr=%h, required all 0",
                         m_req, i_ack, d_ack, i_rvalid, d_rvalid, stall, m_addr);
            end
            inflight = 1'b0; accepted = 1'b0; tb_last = 1'b0; mm_wait = 0; reqcyc = 0;
            sb.delete();
            return;
        end
        cur      = (sb.size() > 0) ? sb[0] : '0;
        exp_comp = inflight && m_rvalid;
        exp_mreq = inflight && !accepted;
        checks++;
        if (m_req !== exp_mreq) begin
            errors++;
            $display("FAIL m_req: got %0b, required %0b (cycle %0d)", m_req, exp_mreq, cyc);
        end
        if (m_req) mreq_cnt++;
        if (exp_mreq) begin
            reqcyc++;
            checks++;
            if (m_addr !== cur.addr || m_wea !== cur.wea || (cur.is_data && m_wdata !== cur.wdata)) begin
                errors++;
                $display("FAIL m_bus: got %h/%b/%h, required %h/%b/%h",
                         m_addr, m_wea, m_wdata, cur.addr, cur.wea, cur.wdata);
            end
            if (m_ready) begin
                checks++;
                if (reqcyc != ready_dly + 1) begin
                    errors++;
                    $display("FAIL req_hold: m_req held %0d cycles, required %0d", reqcyc, ready_dly + 1);
                end
                accepted = 1'b1;
            end
        end
        checks++;
        if (i_rvalid !== (exp_comp && !cur.is_data) || d_rvalid !== (exp_comp && cur.is_data)) begin
            errors++;
            $display("FAIL rvalid: got i=%0b d=%0b, required i=%0b d=%0b",
                     i_rvalid, d_rvalid, exp_comp && !cur.is_data, exp_comp && cur.is_data);
        end
        if (exp_comp && cur.wea == 4'b0000) begin
            checks++;
            if ((cur.is_data ? d_rdata : i_rdata) !== cur.rdata) begin
                errors++;
                $display("FAIL rdata: got %h, required %h", cur.is_data ? d_rdata : i_rdata, cur.rdata);
            end
        end
        checks++;
        if ((!i_rvalid && i_rdata !== '0) || (!d_rvalid && d_rdata !== '0)) begin
            errors++;
            $display("FAIL rdata_idle: got i_rdata=%h d_rdata=%h, required 0 without rvalid", i_rdata, d_rdata);
        end
        elig = !inflight || exp_comp;
`ifdef ARB_ROUND_ROBIN_EN
        win = (i_req && d_req) ? ~tb_last : d_req;
`else
        win = d_req;
`endif
        exp_d_ack = elig && (i_req || d_req) && win;
        exp_i_ack = elig && (i_req || d_req) && !win;
        checks++;
        if (i_ack !== exp_i_ack || d_ack !== exp_d_ack) begin
            errors++;
            $display("FAIL ack: got i=%0b d=%0b, required i=%0b d=%0b (cycle %0d)",
                     i_ack, d_ack, exp_i_ack, exp_d_ack, cyc);
        end
        exp_stall = (inflight && !exp_comp) || (i_req && !exp_i_ack) || (d_req && !exp_d_ack);
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL stall: got %0b, required %0b (cycle %0d)", stall, exp_stall, cyc);
        end
        if (i_ack) i_ack_cnt++;
        if (d_ack) d_ack_cnt++;
        if (i_rvalid) begin i_rv_cnt++; last_i_rdata = i_rdata; end
        if (d_rvalid) d_rv_cnt++;
        if (exp_comp) begin
            void'(sb.pop_front());
            inflight = 1'b0; accepted = 1'b0; comp_cyc = cyc;
        end
        if (exp_i_ack || exp_d_ack) begin
            t         = '0;
            t.is_data = win;
            t.addr    = win ? d_addr : i_addr;
            t.wea     = win ? d_wea : 4'b0000;
            t.wdata   = win ? d_wdata : 32'h0;
            t.rdata   = mem_rd(t.addr);
            sb.push_back(t);
            inflight = 1'b1; accepted = 1'b0; reqcyc = 0; tb_last = win;
            grant_log.push_back(win);
            ack_cycq.push_back(cyc);
            if (win) begin d_todo--; d_addr_n = d_addr_n + 32'd4; end
            else     begin i_todo--; i_addr_n = i_addr_n + 32'd4; end
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst     = rst_cmd;
        i_req   = (i_todo > 0);
        i_addr  = i_addr_n;
        d_req   = (d_todo > 0);
        d_addr  = d_addr_n;
        d_wea   = d_wea_n;
        d_wdata = d_wdata_n;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        if (m_req === 1'b1 && !rst) begin
            if (mm_wait < ready_dly) begin
                mm_wait++;
            end else begin
                m_ready = 1'b1; mm_wait = 0; mm_addr = m_addr;
                if (resp_dly == 0) begin m_rvalid = 1'b1; m_rdata = mem_rd(m_addr); end
                else mm_cnt = resp_dly;
            end
        end else if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin m_rvalid = 1'b1; m_rdata = mem_rd(mm_addr); end
        end
        #1;
        observe();
    endtask

    task automatic run_until_done(input string name);
        int n = 0;
        while ((i_todo > 0 || d_todo > 0 || inflight) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (i_todo > 0 || d_todo > 0 || inflight) begin
            errors++;
            $display("FAIL %s_timeout: pending i=%0d d=%0d inflight=%0b, required all done", name, i_todo, d_todo, inflight);
        end
        step();
    endtask

    task automatic apply_reset();
        rst_cmd = 1'b1;
        step(); step();
        rst_cmd = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_cmd = 1'b1; i_todo = 1; d_todo = 1;
        step(); step(); step();
        i_todo = 0; d_todo = 0; rst_cmd = 1'b0;
        step(); step();
    endtask

    task automatic test_fetch_only();
        clear_counts();
        ready_dly = 0; resp_dly = 2; i_addr_n = 32'h0000_0040; i_todo = 1;
        run_until_done("fetch_only");
        checks++;
        if (i_ack_cnt != 1 || i_rv_cnt != 1 || d_ack_cnt != 0 || d_rv_cnt != 0) begin
            errors++;
            $display("FAIL fetch_pulses: got i_ack=%0d i_rvalid=%0d d_ack=%0d d_rvalid=%0d, required 1 1 0 0",
                     i_ack_cnt, i_rv_cnt, d_ack_cnt, d_rv_cnt);
        end
        checks++;
        if (last_i_rdata !== 32'h2402_000A) begin
            errors++;
            $display("FAIL fetch_rdata: got %h, required 2402000a", last_i_rdata);
        end
    endtask

    task automatic test_data_write();
        clear_counts();
        ready_dly = 3; resp_dly = 1;
        d_addr_n = 32'h10; d_wea_n = 4'b0011; d_wdata_n = 32'hDEAD_BEEF; d_todo = 1;
        run_until_done("data_write");
        checks++;
        if (mreq_cnt != 4 || d_rv_cnt != 1 || i_rv_cnt != 0) begin
            errors++;
            $display("FAIL write_hold: got m_req cycles=%0d d_rvalid=%0d i_rvalid=%0d, required 4 1 0",
                     mreq_cnt, d_rv_cnt, i_rv_cnt);
        end
    endtask

    task automatic test_contention();
        logic exp_order [8];
        apply_reset();
        clear_counts();
        ready_dly = 1; resp_dly = 1;
        i_addr_n = 32'h100; d_addr_n = 32'h200; d_wea_n = 4'b0000; i_todo = 4; d_todo = 4;
        run_until_done("contention");
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_order[k] = (k % 2 == 0);
`else
            exp_order[k] = (k < 4);
`endif
        end
        checks++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL contention_count: got %0d grants, required 8", grant_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (grant_log[k] !== exp_order[k]) begin
                    errors++;
                    $display("FAIL contention_order: grant %0d got %s, required %s", k,
                             grant_log[k] ? "DATA" : "FETCH", exp_order[k] ? "DATA" : "FETCH");
                end
            end
        end
    endtask

    task automatic test_zero_latency();
        clear_counts();
        ready_dly = 0; resp_dly = 0;
        i_addr_n = 32'h300; d_addr_n = 32'h400; d_wea_n = 4'b0000; i_todo = 1; d_todo = 1;
        run_until_done("zero_latency");
        checks++;
        if (ack_cycq.size() != 2) begin
            errors++;
            $display("FAIL zero_latency_grants: got %0d grants, required 2", ack_cycq.size());
        end else if (ack_cycq[1] - ack_cycq[0] != 1 || comp_cyc - ack_cycq[0] != 2) begin
            errors++;
            $display("FAIL zero_latency_timing: got regrant +%0d done +%0d, required +1 +2",
                     ack_cycq[1] - ack_cycq[0], comp_cyc - ack_cycq[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        ready_dly = 2; resp_dly = 0;
        i_addr_n = 32'h800; d_addr_n = 32'h900; d_wea_n = 4'b1111; d_wdata_n = 32'h1234_5678;
        i_todo = 3; d_todo = 3;
        run_until_done("back_to_back");
        ready_dly = $urandom_range(0, 2); resp_dly = $urandom_range(1, 3);
        d_wea_n = 4'b0000; i_todo = 2; d_todo = 2;
        run_until_done("back_to_back_rand");
        checks++;
        if (i_rv_cnt != 5 || d_rv_cnt != 5) begin
            errors++;
            $display("FAIL back_to_back_count: got i_rvalid=%0d d_rvalid=%0d, required 5 5", i_rv_cnt, d_rv_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        clear_counts();
        ready_dly = 0; resp_dly = 6; i_addr_n = 32'h500; i_todo = 1;
        while (!accepted && n < 20) begin step(); n++; end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL midflight_accept: got no acceptance, required one within 20 cycles");
        end
        rst_cmd = 1'b1;
        step(); step();
        rst_cmd = 1'b0;
        clear_counts();
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (i_rv_cnt != 0 || d_rv_cnt != 0 || stall !== 1'b0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL midflight_late: got i_rvalid=%0d d_rvalid=%0d stall=%0b m_req=%0b, required 0 0 0 0",
                     i_rv_cnt, d_rv_cnt, stall, m_req);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_data_write();
        test_contention();
        test_zero_latency();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
